// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential packed-BCD to binary converter.
// Consumes one digit per clock, most significant digit first, using acc = acc*10 + digit.
// Reports the result modulo 2^W, an overflow flag and an invalid-digit flag.
module bcd2bin_seq #(
    parameter int unsigned W      = 18,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [W-1:0]          bin,
    output logic                  ovf,
    output logic                  err
);

    localparam int unsigned ACC_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   sreg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               err_acc;

    logic [3:0]         digit_c;
    logic [ACC_W-1:0]   acc_next_c;
    logic               err_next_c;

    // Next accumulator step: the operand shifts left, so the current digit always sits at the top.
    // acc*10 is formed as (acc<<3)+(acc<<1); 10^DIGITS < 16^DIGITS, so it never wraps.
    always_comb begin
        digit_c    = sreg[ACC_W-1 -: 4];
        acc_next_c = (acc << 3) + (acc << 1) + ACC_W'(digit_c);
        err_next_c = err_acc | (digit_c > 4'd9);
    end

    // Control FSM and datapath registers; done defaults low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= bcd;
                        acc     <= '0;
                        cnt     <= CNT_W'(DIGITS - 1);
                        err_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_next_c;
                    err_acc <= err_next_c;
                    sreg    <= sreg << 4;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        bin   <= W'(acc_next_c);
                        ovf   <= (acc_next_c >> W) != '0;
                        err   <= err_next_c;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Testbench for bcd2bin_seq: directed cases plus a random sweep, checked by a queue-based scoreboard.
module tb_bcd2bin_seq;

    localparam int unsigned W      = 18;
    localparam int unsigned DIGITS = 6;

    typedef struct packed {
        logic [W-1:0] bin;
        logic         ovf;
        logic         err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [4*DIGITS-1:0] bcd = '0;
    logic                busy;
    logic                done;
    logic [W-1:0]        bin;
    logic                ovf;
    logic                err;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    bcd2bin_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .ovf   (ovf),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal value from the digit list with plain arithmetic.
    function automatic exp_t model(input logic [4*DIGITS-1:0] b);
        longint    v;
        logic      e;
        logic [3:0] d;
        exp_t      r;
        v = 0;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = b[4*i +: 4];
            v = v * 10 + longint'(d);
            if (d > 4'd9) e = 1'b1;
        end
        r.bin = W'(v % (longint'(1) << W));
        r.ovf = (v > ((longint'(1) << W) - 1));
        r.err = e;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
        logic [4*DIGITS-1:0] r;
        int m;
        r = '0;
        m = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Issue one conversion at a falling edge once the DUT is idle; returns one cycle after acceptance.
    task automatic convert(input logic [4*DIGITS-1:0] b);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("idle_timeout", 1, 0);
        start = 1'b1;
        bcd   = b;
        q.push_back(model(b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("bin", bin, e.bin);
                    check("ovf", ovf, e.ovf);
                    check("err", err, e.err);
                    check("busy_low_at_done", busy, 0);
                end
            end
        end
    end

    initial begin
        int n;
        int v;
        logic [4*DIGITS-1:0] r;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);

        // Zero operand with busy-length check.
        start = 1'b1;
        bcd   = '0;
        q.push_back(model('0));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, DIGITS);
        check("done_when_busy_falls", done, 1);

        // Boundaries, overflow, invalid digits.
        convert(24'h262143);
        convert(24'h262144);
        convert(24'h999999);
        convert(24'h00012A);
        convert(24'h000042);

        // Start ignored while busy, then back-to-back start in the done cycle.
        convert(24'h000123);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bcd   = 24'h000999;
        @(negedge clk);
        start = 1'b0;
        bcd   = 24'h555555;
        convert(24'h000007);

        // Drain, then reset in the middle of a conversion.
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_before_reset", q.size(), 0);
        check("bin_before_reset", bin, 7);
        start = 1'b1;
        bcd   = 24'h555555;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bin", bin, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_err", err, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);

        // Random sweep of in-range values.
        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(0, 262143));
            convert(to_bcd(v));
        end
        // Random raw words, including invalid digits and overflow.
        for (int i = 0; i < 40; i++) begin
            r = 24'($urandom);
            convert(r);
        end

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("final_drain", q.size(), 0);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter; the inverse of the team's combinational binary-to-BCD block.
- Accepts a packed BCD word, one digit per cycle MSD-first, computing acc = acc*10 + digit.
- Returns a W-bit binary value with overflow and invalid-digit flags.
- Sits on the UART receive path, converting operator-typed decimal fields to binary for the datapath.

Parameters:
- W, 18, binary output width.
- DIGITS, 6, number of BCD digits in input word; bcd[3:0] = ones, bcd[4*DIGITS-1 -: 4] = most significant digit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD operand; captured on accepted start.
- busy  output  1  high while conversion in progress.
- done  output  1  one-cycle pulse; bin/ovf/err valid from this cycle.
- bin  output  W  binary result = full value mod 2^W.
- ovf  output  1  full value > 2^W-1.
- err  output  1  at least one digit > 9.

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, busy=0, done=0, bin=0, ovf=0, err=0; internal accumulator, digit counter and captured operand cleared. Reset overrides every other event, including start and mid-conversion; no done pulse follows.
- FSM: IDLE, CONV.
- IDLE:
  - start=1 at edge 0: capture bcd into shift register, acc=0, cnt=DIGITS-1, err_acc=0, go to CONV.
  - start=0: stay in IDLE.
  - done is forced 0 on every edge where no conversion completes.
- CONV, edges 1..DIGITS, one digit per edge MSD-first:
  - d = captured digit at index cnt.
  - acc <= acc*10 + d, with acc*10 implemented as (acc<<3)+(acc<<1); no multiplier.
  - err_acc <= err_acc | (d > 9).
  - cnt decrements.
- Accumulator width: 4*DIGITS bits; never wraps, since 10^DIGITS < 16^DIGITS.
- Digits > 9 are still accumulated arithmetically with value d; err flags it.
- Last digit (cnt==0) edge, i.e. edge DIGITS:
  - bin <= low W bits of final acc.
  - ovf <= (final acc >> W) != 0.
  - err <= final err flag.
  - done <= 1; state <= IDLE.
- Latency: done visible after edge DIGITS when start is sampled at edge 0.
- busy = (state==CONV): high after edge 0, low after edge DIGITS, coinciding with done=1.
- start while busy: ignored, no queueing; bcd input changes during CONV have no effect.
- Back-to-back: start high in the done cycle is accepted (state already IDLE); the new done arrives DIGITS edges later.
- bin/ovf/err hold their last values until the next completed conversion or reset; they are not cleared on start.
- Throughput: one conversion per DIGITS+1 cycles maximum.

Test Plan (W=18, DIGITS=6):
- Reset, then start with bcd=24'h000000 -> busy high 6 cycles; done after edge 6; bin=0, ovf=0, err=0.
- bcd=24'h262143 -> bin=18'h3FFFF (262143), ovf=0, err=0.
- bcd=24'h262144 -> bin=0, ovf=1. Then bcd=24'h999999 -> bin=213567 (999999-786432), ovf=1, err=0.
- bcd=24'h00012A -> err=1, bin=130, ovf=0. A following conversion of 24'h000042 -> err=0, bin=42.
- Start 24'h000123; pulse start with 24'h000999 at edge 3; assert start again in the done cycle with 24'h000007:
  - First done: bin=123; the edge-3 request is ignored.
  - Second done, 6 edges later: bin=7.
- rst=1 at edge 3 of a conversion of 24'h555555:
  - Next cycle: busy=0, done=0, bin=0.
  - No done pulse appears afterwards.
  - Random sweep of 0..262143, as BCD, checked against a software model: bin equals the value, ovf=0, err=0 throughout.
